// File: rtl/data_mem_ctrl.sv
// Single-port data memory with a valid/ready request and response channel.
// Byte, half and word loads/stores complete with one-cycle latency and flag misaligned or out-of-range accesses.
module data_mem_ctrl #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  state_t state, state_nxt;
  size_t  size;

  logic          accept;
  logic [31:0]   offset;
  logic [29:0]   word_idx;
  logic [1:0]    lane;
  logic [AW-1:0] mem_idx;
  logic          req_err;
  logic          mem_we;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_data;
  logic [31:0]   rsp_rdata_nxt;

  logic [31:0] mem [DEPTH];

  assign size     = size_t'(req_size);
  assign accept   = req_valid & req_ready;
  assign offset   = req_addr - BASE_ADDR;
  assign word_idx = offset[31:2];
  assign lane     = offset[1:0];
  assign mem_idx  = word_idx[AW-1:0];

  // Address decode: error classification, byte enables and lane-replicated store data.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    req_err   = 1'b0;
    byte_en   = 4'b0000;
    wdata_rep = 32'h0;
    unique case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        req_err   = lane[0];
        byte_en   = 4'b0011 << lane;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        req_err   = (lane != 2'b00);
        byte_en   = 4'b1111;
        wdata_rep = req_wdata;
      end
      SZ_ILL: begin
        req_err   = 1'b1;
      end
    endcase
    // A request below the base wraps offset to a huge value, but test it explicitly for clarity.
    if ((req_addr < BASE_ADDR) || (word_idx >= 30'(DEPTH)))
      req_err = 1'b1;
  end

  // Load path: read the addressed word, shift the selected lane down, then extend.
  always_comb begin
    rd_word   = mem[mem_idx];
    rd_shift  = rd_word >> {lane, 3'b000};
    load_data = 32'h0;
    unique case (size)
      SZ_BYTE: load_data = {{24{~req_unsigned & rd_shift[7]}},  rd_shift[7:0]};
      SZ_HALF: load_data = {{16{~req_unsigned & rd_shift[15]}}, rd_shift[15:0]};
      SZ_WORD: load_data = rd_shift;
      SZ_ILL:  load_data = 32'h0;
    endcase
    rsp_rdata_nxt = (req_err || req_we) ? 32'h0 : load_data;
  end

  assign mem_we = accept & req_we & ~req_err & rst_n;

  // NOTE: the storage array has no reset; clearing it would force a flop-based implementation instead of a RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          mem[mem_idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RESP;
      RESP: begin
        if (accept)
          state_nxt = RESP;
        else if (rsp_ready)
          state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    rsp_valid = (state == RESP);
    req_ready = (state == IDLE) | rsp_ready;
  end

  // Response registers load only on accept, so a stalled response stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= req_err;
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words stored; power of two, 4..65536.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; 4-byte aligned.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  request accepted this cycle when req_valid is also high.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 Port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 Port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port rsp_valid  output  1  response present.
REQ-013 Port rsp_ready  input  1  response consumed this cycle when rsp_valid is also high.
REQ-014 Port rsp_rdata  output  32  load result, right-aligned and extended; 0 for stores and errors.
REQ-015 Port rsp_err  output  1  request was misaligned, out of range, or illegal size.

Function
REQ-016 Two states: IDLE (rsp_valid=0) and RESP (rsp_valid=1).
REQ-017 req_ready = (state==IDLE) | rsp_ready; combinational, never depends on req_valid.
REQ-018 Accept = req_valid & req_ready; on accept, state becomes RESP next cycle.
REQ-019 In RESP with rsp_ready=1 and no accept, state becomes IDLE next cycle.
REQ-020 In RESP with rsp_ready=1 and an accept in the same cycle, state stays RESP and the response registers load the new result, giving one response per cycle.
REQ-021 In RESP with rsp_ready=0, rsp_rdata and rsp_err are held stable.
REQ-022 Offset = req_addr - BASE_ADDR; word index = offset[31:2]; lane = offset[1:0].
REQ-023 Error if size=11, size=01 with lane[0]=1, size=10 with lane!=0, req_addr<BASE_ADDR, or word index>=DEPTH.
REQ-024 An errored request never writes memory and returns rsp_err=1, rsp_rdata=0.
REQ-025 Store byte enables: byte 4'b0001<<lane; half 4'b0011<<lane; word 4'b1111.
REQ-026 Store writes the enabled bytes on the accept edge; write data lanes are the replicated wdata bytes shifted to lane.
REQ-027 Load reads the word on the accept edge; the response carries the selected byte/half shifted down by lane and extended per req_unsigned, so latency is 1 cycle.
REQ-028 A load accepted the cycle after a store to the same word returns the stored data.
REQ-029 Storage contents are not reset; reads of never-written words are undefined (X allowed in simulation).
REQ-030 Store response: rsp_err=0, rsp_rdata=0, same handshake as a load.

Reset
REQ-031 While rst_n=0: state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1, and no memory write occurs.
REQ-032 Reset asserted mid-transaction discards any pending response; the first cycle after deassertion is IDLE.

Verification
REQ-033 Store word 32'hDEADBEEF at BASE+8, then load word at BASE+8 -> rsp_rdata=32'hDEADBEEF, rsp_err=0, rsp_valid exactly 1 cycle after accept.
REQ-034 After REQ-033, load byte signed at BASE+11 -> 32'hFFFFFFDE; load byte unsigned at BASE+11 -> 32'h000000DE; load half signed at BASE+8 -> 32'hFFFFBEEF.
REQ-035 Store byte 8'h55 at BASE+9 over 32'hDEADBEEF, then load word -> 32'hDEAD55EF (other bytes intact).
REQ-036 Load word at BASE+2, half at BASE+1, size=11, and word at BASE+4*DEPTH -> each rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-037 Hold rsp_ready=0 for 3 cycles with a response pending -> req_ready=0, response stable; then rsp_ready=1 with back-to-back loads -> one response per cycle, in order.
REQ-038 Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately (asynchronously) and stays 0 until a new accept after release.
